// File: rtl/tdm_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tdm_deserializer
// Description : Receive side of a slotted TDM serial link. Locks to a frame
//               sync pulse and rebuilds the parallel word, one bit per slot.
// Revision    : 1.0  initial release
// ============================================================================
module tdm_deserializer #(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sync,
    input  logic              data_in,
    output logic [SLOTS-1:0]  word_out,
    output logic              word_valid,
    output logic [SLOTS-1:0]  slot_onehot,
    output logic              locked,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              sync_err
);

    localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(SLOTS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SLOT_W-1:0]  r_slot;
    logic [SLOTS-1:0]   r_shadow;
    logic [SLOTS-1:0]   r_word;
    logic               r_valid;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_restart;
    logic               w_capture;
    logic               w_complete;
    logic               w_misalign;
    logic               w_locked;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A restart begins a fresh frame at slot 0; a capture fills the current slot.
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        w_misalign   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && sync) begin
                    w_restart    = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (en) begin
                    if (sync && (r_slot != '0)) begin
                        w_restart  = 1'b1;
                        w_misalign = 1'b1;
                    end else begin
                        w_capture  = 1'b1;
                        w_complete = (r_slot == c_slot_last);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot   <= '0;
            r_shadow <= '0;
            r_word   <= '0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= w_complete;
            if (w_restart) begin
                r_shadow[0] <= data_in;
                r_slot      <= SLOT_W'(1);
            end else if (w_capture) begin
                r_shadow[r_slot] <= data_in;
                r_slot           <= r_slot + SLOT_W'(1);
            end
            // The last bit bypasses the shadow so the word is ready one cycle earlier.
            if (w_complete) begin
                r_word <= {data_in, r_shadow[SLOTS-2:0]};
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (w_misalign) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_locked = (r_state == S_RUN);

    for (genvar k = 0; k < SLOTS; k++) begin : g_onehot
        assign slot_onehot[k] = w_locked && (r_slot == SLOT_W'(k));
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign locked     = w_locked;
    assign frame_cnt  = r_cnt;
    assign sync_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_deserializer
// Description : Directed, table-driven self-checking bench for tdm_deserializer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_deserializer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sync;
    logic       data_in;
    logic [3:0] word_out;
    logic       word_valid;
    logic [3:0] slot_onehot;
    logic       locked;
    logic [7:0] frame_cnt;
    logic       sync_err;

    int errors;
    int checks;

    tdm_deserializer #(.SLOTS(4), .SLOT_W(2), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .data_in     (data_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .slot_onehot (slot_onehot),
        .locked      (locked),
        .frame_cnt   (frame_cnt),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic       sync;
        logic       din;
        logic [3:0] word;
        logic       valid;
        logic       locked;
        logic [7:0] cnt;
        logic       err;
        logic [3:0] oh;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int e, s, d, w, v, l, c, er, oh);
        vec_t r;
        r.en     = e[0];
        r.sync   = s[0];
        r.din    = d[0];
        r.word   = w[3:0];
        r.valid  = v[0];
        r.locked = l[0];
        r.cnt    = c[7:0];
        r.err    = er[0];
        r.oh     = oh[3:0];
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic s, input logic d);
        en      = e;
        sync    = s;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [3:0] w, input logic v,
                           input logic l, input logic [7:0] c, input logic er, input logic [3:0] oh);
        chk({tag, ".word"},   idx, 32'(word_out),    32'(w));
        chk({tag, ".valid"},  idx, 32'(word_valid),  32'(v));
        chk({tag, ".locked"}, idx, 32'(locked),      32'(l));
        chk({tag, ".cnt"},    idx, 32'(frame_cnt),   32'(c));
        chk({tag, ".err"},    idx, 32'(sync_err),    32'(er));
        chk({tag, ".onehot"}, idx, 32'(slot_onehot), 32'(oh));
    endtask

    initial begin
        logic [3:0] n;
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        data_in = 1'b0;

        // Reset held: toggling inputs must not disturb anything.
        step(1'b1, 1'b1, 1'b1);
        chk_all("rst_hold", 0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("rst_hold", 1, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0);
        rst_n = 1'b1;

        // Basic frame 1,0,1,1
        vq.push_back(mk(1,1,1,  0,0,1,0,0,2));
        vq.push_back(mk(1,0,0,  0,0,1,0,0,4));
        vq.push_back(mk(1,0,1,  0,0,1,0,0,8));
        vq.push_back(mk(1,0,1, 13,1,1,1,0,1));
        // Gapped enable, bits 0,1,1,0; sync during en=0 is ignored
        vq.push_back(mk(1,0,0, 13,0,1,1,0,2));
        vq.push_back(mk(0,1,1, 13,0,1,1,0,2));
        vq.push_back(mk(1,0,1, 13,0,1,1,0,4));
        vq.push_back(mk(0,0,0, 13,0,1,1,0,4));
        vq.push_back(mk(1,0,1, 13,0,1,1,0,8));
        vq.push_back(mk(0,1,1, 13,0,1,1,0,8));
        vq.push_back(mk(1,0,0,  6,1,1,2,0,1));
        vq.push_back(mk(0,0,0,  6,0,1,2,0,1));
        // Streaming N=0110, sync aligned to slot 0 is a normal capture
        vq.push_back(mk(1,1,0,  6,0,1,2,0,2));
        vq.push_back(mk(1,0,1,  6,0,1,2,0,4));
        vq.push_back(mk(1,0,1,  6,0,1,2,0,8));
        vq.push_back(mk(1,0,0,  6,1,1,3,0,1));
        vq.push_back(mk(1,0,0,  6,0,1,3,0,2));
        vq.push_back(mk(1,0,1,  6,0,1,3,0,4));
        vq.push_back(mk(1,0,1,  6,0,1,3,0,8));
        vq.push_back(mk(1,0,0,  6,1,1,4,0,1));
        // Misaligned sync at slot 3, then frame 1,1,1,1
        vq.push_back(mk(1,0,1,  6,0,1,4,0,2));
        vq.push_back(mk(1,0,0,  6,0,1,4,0,4));
        vq.push_back(mk(1,0,1,  6,0,1,4,0,8));
        vq.push_back(mk(1,1,1,  6,0,1,4,1,2));
        vq.push_back(mk(1,0,1,  6,0,1,4,1,4));
        vq.push_back(mk(1,0,1,  6,0,1,4,1,8));
        vq.push_back(mk(1,0,1, 15,1,1,5,1,1));
        vq.push_back(mk(0,0,0, 15,0,1,5,1,1));

        foreach (vq[i]) begin
            step(vq[i].en, vq[i].sync, vq[i].din);
            chk_all("vec", i, vq[i].word, vq[i].valid, vq[i].locked, vq[i].cnt, vq[i].err, vq[i].oh);
        end

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        step(1'b1, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1);
        chk_all("async_rst", 1, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0);
        rst_n = 1'b1;

        // Wrap: 255 streamed frames, then the 256th rolls frame_cnt to 0.
        n = 4'b1010;
        for (int f = 0; f < 255; f++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, (f == 0 && k == 0), n[k]);
            end
        end
        chk("wrap.pre_cnt",  0, 32'(frame_cnt),  32'd255);
        chk("wrap.pre_word", 0, 32'(word_out),   32'hA);
        chk("wrap.pre_err",  0, 32'(sync_err),   32'd0);
        n = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, n[k]);
        end
        chk_all("wrap", 0, 4'h5, 1'b1, 1'b1, 8'd0, 1'b0, 4'h1);
        step(1'b0, 1'b0, 1'b0);
        chk_all("wrap", 1, 4'h5, 1'b0, 1'b1, 8'd0, 1'b0, 4'h1);

        // IDLE after reset ignores data without a sync.
        #3;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, k[0]);
            chk_all("idle", k, 4'h0, 1'b0, 1'b0, 8'd0, 1'b0, 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdm_deserializer.md
Name: tdm_deserializer

Overview:
Receive end of the 4-slot time-division serial link, whose transmitter places N[k] on the serial line while its free-running 2-bit slot counter equals k. This block:
- samples the serial bit once per enabled cycle and tracks the slot index with its own counter, aligned by a frame-sync pulse;
- reassembles the parallel word and flags each completed frame with a one-cycle valid pulse.

It sits on the far side of the link from the serialiser, feeding debug probes and downstream logic.

Parameters:
SLOTS, 4, number of bit slots per frame (word width); must be a power of two, >= 2
SLOT_W, 2, slot counter width; equals log2(SLOTS)
CNT_W, 8, width of the completed-frame counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  sample strobe; 1 = sample data_in and advance the slot this cycle
sync  input  1  frame marker; 1 with en = data_in is the slot-0 bit
data_in  input  1  serial bit from the transmitter
word_out  output  SLOTS  last complete frame; bit k = slot-k bit
word_valid  output  1  one-cycle pulse: word_out just updated
slot_onehot  output  SLOTS  one-hot of the slot to be sampled next; all zero when unlocked
locked  output  1  1 while in RUN state
frame_cnt  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W
sync_err  output  1  sticky: sync seen mid-frame; cleared only by reset

Behaviour:
- Reset: asserted asynchronously by rst_n=0, released synchronously to clk.
  - Reset values: state IDLE, slot=0, shadow=0, word_out=0, word_valid=0, locked=0, frame_cnt=0, sync_err=0, slot_onehot=0.
  - Reset mid-frame discards the partial frame; no word_valid is produced for it.
- State machine, 2 states:
  - IDLE: data_in is ignored until en=1 and sync=1. On that edge: shadow[0]<=data_in, slot<=1, state<=RUN.
  - RUN: stays in RUN; leaves only on reset.
- RUN, en=1, sync=0:
  - shadow[slot]<=data_in; slot<=slot+1, wrapping SLOTS-1 -> 0.
  - When slot==SLOTS-1: word_out <= {data_in, shadow[SLOTS-2:0]}; word_valid<=1 for exactly the next cycle; frame_cnt<=frame_cnt+1.
- RUN, en=1, sync=1, slot==0: normal slot-0 capture, identical to the sync=0 case. Back-to-back frames are supported with no gap.
- RUN, en=1, sync=1, slot!=0 (misalignment):
  - sync_err<=1 (sticky).
  - Partial frame discarded: no word_valid, word_out and frame_cnt unchanged.
  - Realign: shadow[0]<=data_in, slot<=1.
- en=0: all state holds; word_valid=0; sync and data_in are ignored.
- word_valid is registered and never high two consecutive cycles (a frame spans at least SLOTS enabled cycles). word_out holds its value between pulses.
- Latency: with en held high and sync with bit 0 at cycle t, the bits are sampled at t..t+SLOTS-1. word_out and word_valid are visible in cycle t+SLOTS.
- slot_onehot = decode of slot when locked, else 0. It is combinational from registered state (glitch-free per cycle).
- frame_cnt: 2^CNT_W-1 + 1 -> 0, with no flag.
- Continuous en=1 with the transmitter's counter free-running: after one sync, a frame completes every SLOTS cycles indefinitely. No further sync is needed.

Test Plan:
- Reset check: hold rst_n=0, toggle inputs -> all outputs 0. Assert rst_n=0 asynchronously mid-RUN -> outputs clear immediately, without a clk edge.
- Basic frame: en=1, sync pulse with data_in sequence 1,0,1,1 (slots 0..3) -> 4 cycles after sync, word_out=4'b1101, word_valid=1 for one cycle, frame_cnt=1, locked=1.
- Streaming: transmitter model with N=4'b0110, counter free-running, sync once -> word_valid every 4 cycles, word_out=4'b0110 each time, frame_cnt increments 1,2,3...
- Gapped enable: en toggling 1,0,1,0 across one frame with bits 0,1,1,0 -> the frame completes after 4 enabled samples, word_out=4'b0110; no state change in en=0 cycles.
- Misalignment: a sync after slot 2 of a frame -> sync_err=1, no word_valid for the broken frame. The next frame 1,1,1,1 -> word_out=4'b1111. sync_err stays 1 until reset.
- Wrap: preload 255 frames (CNT_W=8), complete one more -> frame_cnt=0, word_valid still pulses; IDLE without sync ignores data_in (word_out unchanged, locked=0).
